// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with glitch filter, per-word
// parity/framing/break status and a first-word-fall-through output FIFO.
//
// Stream handshake: a word transfers on every rising clk edge where
// valid && ready. valid stays high while the FIFO holds a word. The head
// word (data/flags) does not change while valid is high and ready is low.
//
// dbg_state exposes the receiver FSM:
//   0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BRKWAIT.
// PULSE_WIDTH = CLK_FREQ/BAUD_RATE must be at least 8.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          uart_in,
  input  logic                          ready,
  input  logic                          clr_overrun,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          break_det,
  output logic                          valid,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overrun,
  output logic [2:0]                    dbg_state
);

  localparam int PULSE_WIDTH = CLK_FREQ / BAUD_RATE;
  localparam int HALF        = PULSE_WIDTH / 2;
  localparam int TW          = $clog2(PULSE_WIDTH);
  localparam int BW          = $clog2(DATA_WIDTH);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int LW          = AW + 1;
  localparam int EW          = DATA_WIDTH + 3;

  localparam logic [TW-1:0] T_FULL   = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] T_HALF   = TW'(HALF - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic          LAST_STP = 1'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [1:0] r_sync;
  logic [2:0] r_win;
  logic       r_rx_f;
  logic       r_rx_prev;
  logic       w_maj;
  logic       w_fall;

  assign w_maj  = (r_win[0] & r_win[1]) | (r_win[0] & r_win[2]) | (r_win[1] & r_win[2]);
  assign w_fall = r_rx_prev & ~r_rx_f;

  // Two-flop synchroniser, 3-sample window and registered majority vote.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync    <= 2'b11;
      r_win     <= 3'b111;
      r_rx_f    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], uart_in};
      r_win     <= {r_win[1:0], r_sync[1]};
      r_rx_f    <= w_maj;
      r_rx_prev <= r_rx_f;
    end
  end

  // ---------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------
  state_t          r_state;
  state_t          w_state_next;
  logic [TW-1:0]   r_tmr;
  logic [BW-1:0]   r_bit_cnt;
  logic            r_stop_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic            r_par_bit;
  logic            r_ferr;
  logic            r_first_stop;
  logic            r_push;
  logic            w_tmr_zero;
  logic            w_ld_half;
  logic            w_ld_full;
  logic            w_clr_frame;
  logic            w_smp_data;
  logic            w_smp_par;
  logic            w_smp_stop;
  logic            w_push_req;

  assign w_tmr_zero = (r_tmr == '0);
  assign dbg_state  = r_state;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    w_state_next = r_state;
    w_ld_half    = 1'b0;
    w_ld_full    = 1'b0;
    w_clr_frame  = 1'b0;
    w_smp_data   = 1'b0;
    w_smp_par    = 1'b0;
    w_smp_stop   = 1'b0;
    w_push_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_state_next = S_START;
          w_ld_half    = 1'b1;
        end
      end
      S_START: begin
        if (w_tmr_zero) begin
          if (!r_rx_f) begin
            w_state_next = S_DATA;
            w_ld_full    = 1'b1;
            w_clr_frame  = 1'b1;
          end else begin
            // Line went back high before mid start bit: false start.
            w_state_next = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (w_tmr_zero) begin
          w_smp_data = 1'b1;
          w_ld_full  = 1'b1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_tmr_zero) begin
          w_smp_par    = 1'b1;
          w_ld_full    = 1'b1;
          w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tmr_zero) begin
          w_smp_stop = 1'b1;
          w_ld_full  = 1'b1;
          if (r_stop_cnt == LAST_STP) begin
            w_push_req   = 1'b1;
            // A low line here means a break or a stuck line; do not treat
            // its continued low level as a new start bit.
            w_state_next = r_rx_f ? S_IDLE : S_BRKWAIT;
          end
        end
      end
      S_BRKWAIT: begin
        if (r_rx_f) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Bit timer, counters, shift register and per-frame status capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmr        <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_ferr       <= 1'b0;
      r_first_stop <= 1'b1;
      r_push       <= 1'b0;
    end else begin
      r_push <= w_push_req;
      if (w_ld_half) begin
        r_tmr <= T_HALF;
      end else if (w_ld_full) begin
        r_tmr <= T_FULL;
      end else if (!w_tmr_zero) begin
        r_tmr <= r_tmr - 1'b1;
      end
      if (w_clr_frame) begin
        r_bit_cnt    <= '0;
        r_stop_cnt   <= 1'b0;
        r_shift      <= '0;
        r_par_bit    <= 1'b0;
        r_ferr       <= 1'b0;
        r_first_stop <= 1'b1;
      end
      if (w_smp_data) begin
        r_shift   <= {r_rx_f, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_smp_par) begin
        r_par_bit <= r_rx_f;
      end
      if (w_smp_stop) begin
        r_stop_cnt <= r_stop_cnt + 1'b1;
        if (r_stop_cnt == 1'b0) begin
          r_first_stop <= r_rx_f;
        end
        if (!r_rx_f) begin
          r_ferr <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Word status, evaluated in the push cycle from the captured frame
  // ---------------------------------------------------------------------
  logic          w_perr;
  logic          w_brk;
  logic          w_xor;
  logic [EW-1:0] w_entry;

  assign w_xor = (^r_shift) ^ r_par_bit;

  // Parity check and break classification.
  always_comb begin
    w_perr = 1'b0;
    w_brk  = (r_shift == '0) && !r_first_stop;
    if (PARITY == 1) begin
      w_perr = w_xor;
      w_brk  = w_brk && !r_par_bit;
    end else if (PARITY == 2) begin
      w_perr = ~w_xor;
      w_brk  = w_brk && !r_par_bit;
    end
  end

  assign w_entry = {w_brk, r_ferr, w_perr, r_shift};

  // ---------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_count;
  logic [EW-1:0] r_last;
  logic          r_ovr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LVL);
  assign w_pop   = !w_empty && ready;
  assign w_wr    = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  // Storage array; entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, occupancy and the last word handed to the consumer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky overrun; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ovr <= 1'b0;
    end else if (w_drop) begin
      r_ovr <= 1'b1;
    end else if (clr_overrun) begin
      r_ovr <= 1'b0;
    end
  end

  // When empty, present the last popped word so outputs never go X.
  assign w_head     = w_empty ? r_last : r_mem[r_rd_ptr];
  assign data       = w_head[DATA_WIDTH-1:0];
  assign parity_err = w_head[DATA_WIDTH];
  assign frame_err  = w_head[DATA_WIDTH+1];
  assign break_det  = w_head[DATA_WIDTH+2];
  assign valid      = !w_empty;
  assign level      = r_count;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: four receiver instances (8N1, 8E1, 8O1, 8N2) at
// 16 clk per bit, table-driven single-frame vectors plus hand-written
// sequences for streaming, break, glitch, overrun and mid-frame reset.
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 16;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_BRKWAIT = 3'd5;

  logic       clk;
  logic       rstn;
  logic       line    [4];
  logic       rdy     [4];
  logic       clr     [4];
  logic [7:0] q_data  [4];
  logic       q_perr  [4];
  logic       q_ferr  [4];
  logic       q_brk   [4];
  logic       q_valid [4];
  logic [4:0] q_level [4];
  logic       q_ovr   [4];
  logic [2:0] q_state [4];

  int checks;
  int failures;
  logic [7:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_rx_fifo #(
      .DATA_WIDTH(8),
      .BAUD_RATE (100_000),
      .CLK_FREQ  (1_600_000),
      .PARITY    ((g == 1) ? 1 : ((g == 2) ? 2 : 0)),
      .STOP_BITS ((g == 3) ? 2 : 1),
      .FIFO_DEPTH(16)
    ) u_dut (
      .clk        (clk),
      .rstn       (rstn),
      .uart_in    (line[g]),
      .ready      (rdy[g]),
      .clr_overrun(clr[g]),
      .data       (q_data[g]),
      .parity_err (q_perr[g]),
      .frame_err  (q_ferr[g]),
      .break_det  (q_brk[g]),
      .valid      (q_valid[g]),
      .level      (q_level[g]),
      .overrun    (q_ovr[g]),
      .dbg_state  (q_state[g])
    );
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input int idx, input logic b);
    line[idx] = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // Start bit, 8 data bits LSB first, parity on instances 1/2, one stop
  // bit (two on instance 3), then two idle bit times.
  task automatic send_frame(input int idx, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops);
    send_bit(idx, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(idx, d[i]);
    if (idx == 1 || idx == 2) send_bit(idx, pbit);
    send_bit(idx, stops[0]);
    if (idx == 3) send_bit(idx, stops[1]);
    send_bit(idx, 1'b1);
    send_bit(idx, 1'b1);
  endtask

  task automatic pop(input int idx);
    rdy[idx] = 1'b1;
    @(negedge clk);
    rdy[idx] = 1'b0;
  endtask

  task automatic chk_head(input string nm, input int idx, input logic [7:0] d,
                          input logic pe, input logic fe, input logic bk);
    chk({nm, "_valid"}, q_valid[idx], 1'b1);
    chk({nm, "_data"},  q_data[idx],  d);
    chk({nm, "_perr"},  q_perr[idx],  pe);
    chk({nm, "_ferr"},  q_ferr[idx],  fe);
    chk({nm, "_brk"},   q_brk[idx],   bk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         idx;
    logic [7:0] din;
    logic       pbit;
    logic [1:0] stops;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_ferr;
    logic       e_brk;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int vcnt;
    int saw_other;
    int saw_start;
    int saw_data;
    logic [7:0] cap;
    logic [7:0] e;

    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      line[i] = 1'b1;
      rdy[i]  = 1'b0;
      clr[i]  = 1'b0;
    end

    //             idx din    pbit stops  data   pe ferr brk
    vecs[0]  = '{0, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{0, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1, 8'h03, 1'b1, 2'b11, 8'h03, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2, 8'h03, 1'b1, 2'b11, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2, 8'h07, 1'b1, 2'b11, 8'h07, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3, 8'h55, 1'b0, 2'b01, 8'h55, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{3, 8'h55, 1'b0, 2'b11, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{0, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{3, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", q_valid[0], 1'b0);
    chk("rst_data",  q_data[0],  8'h00);
    chk("rst_flags", {q_perr[0], q_ferr[0], q_brk[0]}, 3'b000);
    chk("rst_level", q_level[0], 5'd0);
    chk("rst_ovr",   q_ovr[0],   1'b0);
    chk("rst_state", q_state[0], ST_IDLE);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven single frames: check head, pop, check empty and hold.
    for (int v = 0; v < 13; v++) begin
      send_frame(vecs[v].idx, vecs[v].din, vecs[v].pbit, vecs[v].stops);
      chk_head($sformatf("vec%0d", v), vecs[v].idx, vecs[v].e_data,
               vecs[v].e_perr, vecs[v].e_ferr, vecs[v].e_brk);
      chk($sformatf("vec%0d_level", v), q_level[vecs[v].idx], 5'd1);
      pop(vecs[v].idx);
      chk($sformatf("vec%0d_empty", v), q_valid[vecs[v].idx], 1'b0);
      chk($sformatf("vec%0d_hold", v), q_data[vecs[v].idx], vecs[v].e_data);
    end

    // Streaming with ready held high: valid for exactly one cycle.
    rdy[0] = 1'b1;
    vcnt = 0;
    cap  = 8'h00;
    fork
      send_frame(0, 8'hA5, 1'b0, 2'b11);
      for (int i = 0; i < 12 * BIT_CLKS; i++) begin
        @(negedge clk);
        if (q_valid[0]) begin
          vcnt++;
          cap = q_data[0];
        end
      end
    join
    rdy[0] = 1'b0;
    chk("stream_valid_cycles", vcnt, 1);
    chk("stream_data", cap, 8'hA5);
    chk("stream_level", q_level[0], 5'd0);

    // Break: line low 30 bit times -> one break word, then a clean frame.
    line[0] = 1'b0;
    repeat (30 * BIT_CLKS) @(negedge clk);
    chk("brk_level_low", q_level[0], 5'd1);
    chk("brk_state", q_state[0], ST_BRKWAIT);
    line[0] = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(0, 8'h3C, 1'b0, 2'b11);
    chk("brk_level", q_level[0], 5'd2);
    chk_head("brk_word", 0, 8'h00, 1'b0, 1'b1, 1'b1);
    pop(0);
    chk_head("after_brk", 0, 8'h3C, 1'b0, 1'b0, 1'b0);
    pop(0);

    // One-clock glitch: FSM never leaves IDLE.
    saw_other = 0;
    for (int i = 0; i < 40; i++) begin
      line[0] = (i < 1) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (q_state[0] != ST_IDLE) saw_other = 1;
    end
    chk("glitch_state", saw_other, 0);
    chk("glitch_level", q_level[0], 5'd0);

    // Six-clock low pulse: false start, back to IDLE, no word.
    saw_start = 0;
    saw_data  = 0;
    for (int i = 0; i < 40; i++) begin
      line[0] = (i < 6) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (q_state[0] == ST_START) saw_start = 1;
      if (q_state[0] == ST_DATA)  saw_data  = 1;
    end
    chk("fstart_seen", saw_start, 1);
    chk("fstart_no_data", saw_data, 0);
    chk("fstart_idle", q_state[0], ST_IDLE);
    repeat (12 * BIT_CLKS) @(negedge clk);
    chk("fstart_level", q_level[0], 5'd0);

    // Overrun: 17 frames into a 16-deep FIFO with ready low.
    for (int i = 0; i < 17; i++) begin
      send_frame(0, 8'(i), 1'b0, 2'b11);
      if (i < 16) exp_q.push_back(8'(i));
    end
    chk("ovr_level", q_level[0], 5'd16);
    chk("ovr_flag", q_ovr[0], 1'b1);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("drain%0d_valid", i), q_valid[0], 1'b1);
      chk($sformatf("drain%0d_data", i), q_data[0], e);
      pop(0);
    end
    chk("drain_level", q_level[0], 5'd0);
    chk("drain_hold", q_data[0], 8'h0F);
    chk("ovr_sticky", q_ovr[0], 1'b1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovr_clr", q_ovr[0], 1'b0);

    // Mid-frame reset with a word already buffered.
    send_frame(0, 8'h99, 1'b0, 2'b11);
    chk("prerst_level", q_level[0], 5'd1);
    fork
      send_frame(0, 8'h7E, 1'b0, 2'b11);
      begin
        repeat (5 * BIT_CLKS + 8) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midrst_valid", q_valid[0], 1'b0);
        chk("midrst_data",  q_data[0],  8'h00);
        chk("midrst_level", q_level[0], 5'd0);
        chk("midrst_state", q_state[0], ST_IDLE);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
      end
    join
    // Let the tail of the interrupted frame settle, then flush it.
    repeat (10 * BIT_CLKS) @(negedge clk);
    for (int k = 0; k < 20 && q_valid[0]; k++) pop(0);
    chk("flush_empty", q_valid[0], 1'b0);
    send_frame(0, 8'h81, 1'b0, 2'b11);
    chk_head("post_rst", 0, 8'h81, 1'b0, 1'b0, 1'b0);
    chk("post_rst_level", q_level[0], 5'd1);
    pop(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #5_000_000;
    failures++;
    $display("FAIL timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
